smm_operand_feeder: RTL and testbench

Skewed operand transmitter for the 3×3 systolic matrix multiplier (SMM). It accepts two full N×N operand matrices in one handshake and drives them onto the array's left edge (A rows) and top edge (B columns) with the diagonal skew that output-stationary PEs require. It clears the PE accumulators on the first beat and pulses `done` once the last product has settled in the array. It sits between the operand source (loader, DMA or bench) and the SMM core, replacing direct full-matrix drive of the array.

---
 rtl/smm_pkg.sv | 10 +
 rtl/smm_skew_sel.sv | 18 +
 rtl/smm_operand_feeder.sv | 75 +++++++
 tb/tb_smm_operand_feeder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/smm_pkg.sv
// smm_pkg: shared constants, operand/edge types and feeder state enum for the SMM
package smm_pkg;
  localparam int BW = 8;
  localparam int N = 3;
  localparam int IW = $clog2(N);
  typedef logic [BW-1:0] elem_t;
  typedef elem_t mat_t [N][N];
  typedef elem_t edge_t [N];
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feed_state_e;
endpackage

// File: rtl/smm_skew_sel.sv
// smm_skew_sel: picks lane's skewed element m[lane][t-lane] (or m[t-lane][lane] when TR) at beat t, else 0
module smm_skew_sel
  import smm_pkg::*;
#(
  parameter bit TR = 1'b0,
  parameter int CW = 4
) (
  input  logic [CW-1:0] t,
  input  logic [CW-1:0] lane,
  input  mat_t          m,
  output elem_t         q
);
  logic [CW-1:0] d;
  always_comb begin
    d = t - lane;
    q = (t >= lane && d < CW'(N)) ? (TR ? m[d[IW-1:0]][lane[IW-1:0]] : m[lane[IW-1:0]][d[IW-1:0]]) : '0;
  end
endmodule

// File: rtl/smm_operand_feeder.sv
// smm_operand_feeder: captures A/B on in_valid&&in_ready, drives skewed a_edge/b_edge with edge_valid/acc_clr, then drains and pulses done; busy/in_ready report state
module smm_operand_feeder
  import smm_pkg::*;
#(
  parameter int PE_LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  mat_t  A_in,
  input  mat_t  B_in,
  output edge_t a_edge,
  output edge_t b_edge,
  output logic  edge_valid,
  output logic  acc_clr,
  output logic  busy,
  output logic  done
);
  localparam int CW = $clog2(3 * N + PE_LAT);
  feed_state_e state, nxt;
  logic [CW-1:0] t, t_n;
  logic accept, last;
  mat_t a_q, b_q, a_src, b_src;
  edge_t a_sel, b_sel, a_nx, b_nx;
  for (genvar i = 0; i < N; i++) begin : g_lane
    smm_skew_sel #(.TR(1'b0), .CW(CW)) u_a (.t(t_n), .lane(CW'(i)), .m(a_src), .q(a_sel[i]));
    smm_skew_sel #(.TR(1'b1), .CW(CW)) u_b (.t(t_n), .lane(CW'(i)), .m(b_src), .q(b_sel[i]));
  end
  always_comb begin
    accept = in_valid && state == IDLE;
    last = (state == FEED && t == CW'(2 * N - 2)) || (state == DRAIN && t == CW'(N - 2 + PE_LAT));
    t_n = ((state == FEED || state == DRAIN) && !last) ? t + CW'(1) : '0;
    nxt = state == IDLE  ? (in_valid ? FEED : IDLE) :
          state == FEED  ? (last ? DRAIN : FEED) :
          state == DRAIN ? (last ? DONE : DRAIN) : IDLE;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_src[i][j] = accept ? A_in[i][j] : a_q[i][j];
        b_src[i][j] = accept ? B_in[i][j] : b_q[i][j];
      end
      a_nx[i] = nxt == FEED ? a_sel[i] : '0;
      b_nx[i] = nxt == FEED ? b_sel[i] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      a_edge <= '{default: '0};
      b_edge <= '{default: '0};
      edge_valid <= 1'b0;
      acc_clr <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state <= nxt;
      t <= t_n;
      if (accept) begin
        a_q <= A_in;
        b_q <= B_in;
      end
      a_edge <= a_nx;
      b_edge <= b_nx;
      edge_valid <= nxt == FEED;
      acc_clr <= accept;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      in_ready <= nxt == IDLE;
    end
  end
endmodule

// File: tb/tb_smm_operand_feeder.sv
// tb_smm_operand_feeder: directed checks of skew, timing, back-to-back, busy-ignore, reset and input-hold behaviour
module tb_smm_operand_feeder;
  import smm_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, edge_valid, acc_clr, busy, done;
  mat_t A_in, B_in, ma, mi, m2, mf;
  edge_t a_edge, b_edge;
  int checks = 0;
  int errors = 0;
  int ndone = 0;
  int base;
  smm_operand_feeder #(.PE_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .B_in(B_in), .a_edge(a_edge), .b_edge(b_edge),
    .edge_valid(edge_valid), .acc_clr(acc_clr), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done) ndone <= ndone + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pk(input edge_t e);
    return {8'h00, e[0], e[1], e[2]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] b);
    check({tag, "_a"}, pk(a_edge), a);
    check({tag, "_b"}, pk(b_edge), b);
  endtask
  task automatic idle_chk(input string tag);
    check({tag, "_rdy"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ev"}, edge_valid, 0);
    check({tag, "_clr"}, acc_clr, 0);
    check({tag, "_done"}, done, 0);
    beat(tag, 0, 0);
  endtask
  task automatic start(input mat_t a, input mat_t b);
    A_in = a;
    B_in = b;
    in_valid = 1'b1;
    step();
  endtask
  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = elem_t'(3 * i + j + 1);
        mi[i][j] = elem_t'(i == j);
        m2[i][j] = 8'd2;
        mf[i][j] = 8'hff;
      end
    A_in = ma;
    B_in = mi;
    step();
    step();
    idle_chk("reset");
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst_wins_busy", busy, 0);
    check("rst_wins_rdy", in_ready, 1);
    base = ndone;
    start(ma, mi);
    in_valid = 1'b0;
    A_in = mf;
    beat("b0", 32'h010000, 32'h010000);
    check("b0_clr", acc_clr, 1);
    check("b0_ev", edge_valid, 1);
    check("b0_rdy", in_ready, 0);
    step();
    beat("b1", 32'h020400, 32'h000000);
    check("b1_clr", acc_clr, 0);
    step();
    beat("hold_b2", 32'h030507, 32'h000100);
    step();
    beat("b3", 32'h000608, 32'h000000);
    step();
    beat("b4", 32'h000009, 32'h000001);
    check("b4_ev", edge_valid, 1);
    for (int c = 6; c <= 10; c++) begin
      step();
      check($sformatf("c%0d_ev", c), edge_valid, 0);
      check($sformatf("c%0d_done", c), done, c == 9);
      check($sformatf("c%0d_rdy", c), in_ready, c == 10);
      check($sformatf("c%0d_busy", c), busy, c != 10);
    end
    check("job1_dones", ndone - base, 1);
    base = ndone;
    start(ma, mi);
    B_in = m2;
    for (int c = 2; c <= 10; c++) step();
    check("b2b_rdy10", in_ready, 1);
    step();
    beat("b2b_b0", 32'h010000, 32'h020000);
    check("b2b_clr", acc_clr, 1);
    step();
    beat("b2b_b1", 32'h020400, 32'h020200);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("b2b_dones", ndone - base, 2);
    base = ndone;
    start(ma, mi);
    in_valid = 1'b0;
    step();
    step();
    beat("ign_c3", 32'h030507, 32'h000100);
    A_in = mf;
    B_in = m2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat("ign_c4", 32'h000608, 32'h000000);
    for (int c = 5; c <= 8; c++) step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ign_done9", done, 1);
    for (int c = 10; c <= 12; c++) step();
    check("ign_dones", ndone - base, 1);
    check("ign_ev", edge_valid, 0);
    check("ign_rdy", in_ready, 1);
    base = ndone;
    start(ma, mi);
    in_valid = 1'b0;
    for (int c = 2; c <= 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_chk("rst_mid");
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat("rst_new_b0", 32'h010000, 32'h010000);
    check("rst_new_clr", acc_clr, 1);
    for (int c = 8; c <= 16; c++) step();
    check("rst_dones", ndone - base, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
